// File: rtl/ss_score_display_if.sv
// Bundles the scan-select, value-load and display-drive signals of ss_score_display.
// state is a read-only debug view of the conversion FSM.
interface ss_score_display_if;
  logic [2:0]  sel;
  logic [13:0] score;
  logic [13:0] hiscore;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic [1:0]  state;

  modport master (output sel, score, hiscore, load,
                  input  an, seg, dp, busy, state);
  modport slave  (input  sel, score, hiscore, load,
                  output an, seg, dp, busy, state);
endinterface

// File: rtl/ss_score_display.sv
// Two-value score display: double-dabble BCD conversion of score/hiscore and a
// registered digit driver for an 8-digit multiplexed seven-segment display.
module ss_score_display #(
  parameter bit         BLANK_EN = 1'b1,
  parameter logic [3:0] DP_DIGIT = 4'd4
) (
  input logic              clk,
  input logic              rst,
  ss_score_display_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] sc_bin_q, sc_bin_d, hi_bin_q, hi_bin_d;
  logic [15:0] sc_bcd_q, sc_bcd_d, hi_bcd_q, hi_bcd_d;
  logic [15:0] sc_disp_q, sc_disp_d, hi_disp_q, hi_disp_d;
  logic        pend_q, pend_d;
  logic [13:0] pend_sc_q, pend_sc_d, pend_hi_q, pend_hi_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [29:0] sc_step, hi_step;
  logic [15:0] grp;
  logic [3:0]  nib;
  logic [1:0]  idx;
  logic        blank;

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  function automatic logic [29:0] dabble(input logic [15:0] bcd, input logic [13:0] bin);
    logic [15:0] t;
    t = bcd;
    for (int k = 0; k < 4; k++) begin
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    end
    return {t[14:0], bin, 1'b0};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sc_bin_d  = sc_bin_q;
    hi_bin_d  = hi_bin_q;
    sc_bcd_d  = sc_bcd_q;
    hi_bcd_d  = hi_bcd_q;
    sc_disp_d = sc_disp_q;
    hi_disp_d = hi_disp_q;
    pend_d    = pend_q;
    pend_sc_d = pend_sc_q;
    pend_hi_d = pend_hi_q;
    sc_step   = dabble(sc_bcd_q, sc_bin_q);
    hi_step   = dabble(hi_bcd_q, hi_bin_q);
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          sc_bin_d = clamp(bus.score);
          hi_bin_d = clamp(bus.hiscore);
          sc_bcd_d = '0;
          hi_bcd_d = '0;
          cnt_d    = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        {sc_bcd_d, sc_bin_d} = sc_step;
        {hi_bcd_d, hi_bin_d} = hi_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = COMMIT;
        if (bus.load) begin
          pend_d    = 1'b1;
          pend_sc_d = clamp(bus.score);
          pend_hi_d = clamp(bus.hiscore);
        end
      end
      COMMIT: begin
        sc_disp_d = sc_bcd_q;
        hi_disp_d = hi_bcd_q;
        // A load arriving in this very cycle is newer than any shadowed one.
        if (bus.load || pend_q) begin
          pend_d   = 1'b0;
          sc_bin_d = bus.load ? clamp(bus.score)   : pend_sc_q;
          hi_bin_d = bus.load ? clamp(bus.hiscore) : pend_hi_q;
          sc_bcd_d = '0;
          hi_bcd_d = '0;
          cnt_d    = '0;
          state_d  = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx   = bus.sel[1:0];
    grp   = bus.sel[2] ? hi_disp_q : sc_disp_q;
    nib   = grp[{idx, 2'b00} +: 4];
    blank = BLANK_EN && (idx != 2'd0);
    for (int k = 0; k < 4; k++) begin
      if ((2'(k) >= idx) && (grp[4*k +: 4] != 4'd0)) blank = 1'b0;
    end
    case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'h7F;
    endcase
    an_d = ~(8'd1 << bus.sel);
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end
    dp_d = !(({1'b0, bus.sel} == DP_DIGIT) && !blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sc_bin_q  <= '0;
      hi_bin_q  <= '0;
      sc_bcd_q  <= '0;
      hi_bcd_q  <= '0;
      sc_disp_q <= '0;
      hi_disp_q <= '0;
      pend_q    <= 1'b0;
      pend_sc_q <= '0;
      pend_hi_q <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sc_bin_q  <= sc_bin_d;
      hi_bin_q  <= hi_bin_d;
      sc_bcd_q  <= sc_bcd_d;
      hi_bcd_q  <= hi_bcd_d;
      sc_disp_q <= sc_disp_d;
      hi_disp_q <= hi_disp_d;
      pend_q    <= pend_d;
      pend_sc_q <= pend_sc_d;
      pend_hi_q <= pend_hi_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_ss_score_display.sv
// Bench for ss_score_display: two instances (blanking on / off) driven in lockstep,
// checked against a decimal-arithmetic display model through expected-value queues.
module tb_ss_score_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ss_score_display_if bus0 ();
  ss_score_display_if bus1 ();

  ss_score_display #(.BLANK_EN(1'b1), .DP_DIGIT(4'd4)) u_dut (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  ss_score_display #(.BLANK_EN(1'b0), .DP_DIGIT(4'd8)) u_dut_nb (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int   m_sc, m_hi;
  logic chk_v;
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display model: decimal digit of the clamped value; blanked when below 10^n.
  function automatic logic [15:0] expect_disp(input bit blank_en, input int dp_digit,
                                              input int sc, input int hi, input int s);
    int v, n, p, dig;
    logic [7:0] an_e;
    v   = (s >= 4) ? hi : sc;
    if (v > 9999) v = 9999;
    n   = s % 4;
    p   = (n == 0) ? 1 : (n == 1) ? 10 : (n == 2) ? 100 : 1000;
    dig = (v / p) % 10;
    if (blank_en && n != 0 && v < p) return {8'hFF, 7'h7F, 1'b1};
    an_e    = 8'hFF;
    an_e[s] = 1'b0;
    return {an_e, seg_tab[dig], (s == dp_digit) ? 1'b0 : 1'b1};
  endfunction

  initial begin : monitor
    bit armed;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      armed = chk_v;
      @(negedge clk);
      if (armed) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          e = exp_q0.pop_front();
          check("disp_blank", {bus0.an, bus0.seg, bus0.dp}, e);
          e = exp_q1.pop_front();
          check("disp_noblank", {bus1.an, bus1.seg, bus1.dp}, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int s);
    bus0.sel = 3'(s);
    bus1.sel = 3'(s);
    chk_v = 1'b1;
    exp_q0.push_back(expect_disp(1'b1, 4, m_sc, m_hi, s));
    exp_q1.push_back(expect_disp(1'b0, 8, m_sc, m_hi, s));
    @(negedge clk);
    chk_v = 1'b0;
  endtask

  task automatic sweep();
    int off;
    off = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) show((i + off) % 8);
  endtask

  task automatic start_load(input int sc, input int hi);
    bus0.score = 14'(sc);   bus1.score = 14'(sc);
    bus0.hiscore = 14'(hi); bus1.hiscore = 14'(hi);
    bus0.load = 1'b1;       bus1.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;       bus1.load = 1'b0;
  endtask

  task automatic chk_busy(input bit exp);
    check("busy_blank", bus0.busy, exp);
    check("busy_noblank", bus1.busy, exp);
  endtask

  task automatic chk_reset();
    check("rst_an", bus0.an, 8'hFF);
    check("rst_seg", bus0.seg, 7'h7F);
    check("rst_dp", bus0.dp, 1);
    check("rst_state", bus0.state, 0);
    check("rst_an_nb", bus1.an, 8'hFF);
    check("rst_dp_nb", bus1.dp, 1);
    chk_busy(1'b0);
  endtask

  // Single conversion: old values visible through edge N+15, new ones afterwards.
  task automatic conv_check(input int sc, input int hi);
    start_load(sc, hi);
    sweep();
    step(6);
    chk_busy(1'b1);
    show(0);
    chk_busy(1'b0);
    m_sc = sc;
    m_hi = hi;
    sweep();
  endtask

  initial begin : driver
    int a, b, h2, h3;
    rst = 1'b1;
    chk_v = 1'b0;
    m_sc = 0;
    m_hi = 0;
    bus0.sel = '0; bus1.sel = '0;
    bus0.score = '0; bus1.score = '0;
    bus0.hiscore = '0; bus1.hiscore = '0;
    bus0.load = 1'b0; bus1.load = 1'b0;
    step(3);
    chk_reset();
    rst = 1'b0;
    sweep();

    conv_check(1234, 56);
    conv_check(16383, 10000);
    conv_check(5, 0);
    conv_check(0, 9999);

    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 16383);
      b = $urandom_range(0, 16383);
      conv_check(a, b);
    end

    // Three loads: the second is superseded by the third while the first converts.
    a  = $urandom_range(0, 9999);
    b  = $urandom_range(0, 9999);
    h2 = $urandom_range(0, 16383);
    h3 = $urandom_range(0, 16383);
    start_load(a, b);
    step(4);
    start_load(7, h2);
    step(3);
    start_load(8, h3);
    step(5);
    chk_busy(1'b1);
    step(1);
    chk_busy(1'b1);
    m_sc = a;
    m_hi = b;
    show(0);
    step(13);
    chk_busy(1'b1);
    step(1);
    chk_busy(1'b0);
    m_sc = 8;
    m_hi = h3;
    sweep();

    // Load landing in the commit cycle chains straight into a new conversion.
    a  = $urandom_range(0, 16383);
    b  = $urandom_range(0, 16383);
    h2 = $urandom_range(0, 16383);
    h3 = $urandom_range(0, 16383);
    start_load(a, b);
    step(14);
    start_load(h2, h3);
    chk_busy(1'b1);
    m_sc = a;
    m_hi = b;
    show(4);
    step(13);
    chk_busy(1'b1);
    step(1);
    chk_busy(1'b0);
    m_sc = h2;
    m_hi = h3;
    sweep();

    // Reset in the middle of a conversion discards everything.
    start_load(4321, $urandom_range(1, 9999));
    step(6);
    chk_busy(1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    m_sc = 0;
    m_hi = 0;
    sweep();
    conv_check($urandom_range(0, 9999), $urandom_range(0, 9999));

    step(3);
    check("queue_drain", exp_q0.size() + exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
